// File: rtl/fifo_reader.sv
// fifo_reader: read-side master for the generic FIFO. Issues paced reads,
// packs RATIO returned words into one beat and buffers beats in a 2-entry
// output queue so downstream backpressure never loses data.
module fifo_reader #(
   parameter int WIDTH = 4,
   parameter int RATIO = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   output logic                     fifo_rd_valid,
   input  logic [WIDTH-1:0]         fifo_rd_data,
   input  logic                     fifo_rd_ready,
   input  logic                     fifo_empty,
   input  logic                     fifo_underflow,
   output logic                     out_valid,
   output logic [WIDTH*RATIO-1:0]   out_data,
   input  logic                     out_ready,
   output logic                     busy,
   output logic                     err_underflow,
   output logic                     err_unexpected
);

   localparam int BW = WIDTH * RATIO;
   localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

   logic [1:0]    run_q, run_d;
   logic          req_q, req_d;
   logic [CW-1:0] pack_cnt_q, pack_cnt_d;
   logic [BW-1:0] pack_q, pack_d;
   logic [1:0]    occ_q, occ_d;
   logic [BW-1:0] q0_q, q0_d;
   logic [BW-1:0] q1_q, q1_d;
   logic          err_uf_q, err_uf_d;
   logic          err_ux_q, err_ux_d;

   logic [BW-1:0] beat;
   logic          push;
   logic          pop;
   logic          room;

   // Request pacing: one outstanding read at a time hides the lagging empty flag.
   // pack_cnt never exceeds LAST, so "!= LAST" is the same as "< RATIO-1".
   always_comb begin
      room          = (occ_q != 2'd2) || (pack_cnt_q != LAST);
      fifo_rd_valid = run_q[1] & en & ~fifo_empty & ~req_q & room;
      req_d         = fifo_rd_valid;
      run_d         = {run_q[0], 1'b1};
   end

   // Pack returned words into the current beat; full beat is pushed to the queue.
   always_comb begin
      beat = pack_q;
      for (int unsigned i = 0; i < RATIO; i++) begin
         if (pack_cnt_q == CW'(i)) beat[i*WIDTH +: WIDTH] = fifo_rd_data;
      end
      push       = fifo_rd_ready && (pack_cnt_q == LAST);
      pack_d     = pack_q;
      pack_cnt_d = pack_cnt_q;
      if (fifo_rd_ready) begin
         pack_d     = beat;
         pack_cnt_d = push ? '0 : pack_cnt_q + 1'b1;
      end
   end

   // Two-entry output queue; q0 is always the head so out_data comes from a flop.
   always_comb begin
      pop   = (occ_q != 2'd0) && out_ready;
      occ_d = occ_q;
      q0_d  = q0_q;
      q1_d  = q1_q;
      case ({push, pop})
         2'b10: begin
            if (occ_q == 2'd0) q0_d = beat;
            else               q1_d = beat;
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            q0_d  = q1_q;
            occ_d = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               q0_d = beat;
            end else begin
               q0_d = q1_q;
               q1_d = beat;
            end
         end
         default: ;
      endcase
   end

   // Sticky error flags, cleared only by reset.
   always_comb begin
      err_uf_d = err_uf_q | fifo_underflow;
      err_ux_d = err_ux_q | (fifo_rd_ready & ~req_q);
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q      <= '0;
         req_q      <= 1'b0;
         pack_cnt_q <= '0;
         pack_q     <= '0;
         occ_q      <= '0;
         q0_q       <= '0;
         q1_q       <= '0;
         err_uf_q   <= 1'b0;
         err_ux_q   <= 1'b0;
      end else begin
         run_q      <= run_d;
         req_q      <= req_d;
         pack_cnt_q <= pack_cnt_d;
         pack_q     <= pack_d;
         occ_q      <= occ_d;
         q0_q       <= q0_d;
         q1_q       <= q1_d;
         err_uf_q   <= err_uf_d;
         err_ux_q   <= err_ux_d;
      end
   end

   assign out_valid      = (occ_q != 2'd0);
   assign out_data       = q0_q;
   assign busy           = req_q | (pack_cnt_q != '0) | (occ_q != 2'd0);
   assign err_underflow  = err_uf_q;
   assign err_unexpected = err_ux_q;

   // The request rule guarantees a free slot for every push.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && occ_q == 2'd2));

endmodule

// File: tb/tb_fifo_reader.sv
// Testbench for fifo_reader: two instances (RATIO=1 and RATIO=2) fed by a
// small FIFO model with 1-cycle read latency and a lagging empty flag.
module tb_fifo_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [1:0] en, out_ready, rd_valid, m_ready, m_uf, inj_ready, inj_uf;
   logic [1:0] out_valid, busy, err_uf, err_ux;
   logic [1:0] empty = 2'b11;
   logic [3:0] m_data [2];
   logic [3:0] inj_data;
   logic [3:0] out_data0;
   logic [7:0] out_data1;
   logic [3:0] mem [2][16];
   logic [3:0] rp [2] = '{4'd0, 4'd0};
   logic [3:0] wp [2] = '{4'd0, 4'd0};
   logic [3:0] rd_data0, rd_data1;
   logic       rdy0, rdy1, uf0, uf1;

   int n_chk  = 0;
   int n_fail = 0;

   assign rd_data0 = inj_ready[0] ? inj_data : m_data[0];
   assign rd_data1 = inj_ready[1] ? inj_data : m_data[1];
   assign rdy0     = m_ready[0] | inj_ready[0];
   assign rdy1     = m_ready[1] | inj_ready[1];
   assign uf0      = m_uf[0] | inj_uf[0];
   assign uf1      = m_uf[1] | inj_uf[1];

   fifo_reader #(.WIDTH(4), .RATIO(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .en(en[0]), .fifo_rd_valid(rd_valid[0]),
      .fifo_rd_data(rd_data0), .fifo_rd_ready(rdy0), .fifo_empty(empty[0]),
      .fifo_underflow(uf0), .out_valid(out_valid[0]), .out_data(out_data0),
      .out_ready(out_ready[0]), .busy(busy[0]), .err_underflow(err_uf[0]),
      .err_unexpected(err_ux[0]));

   fifo_reader #(.WIDTH(4), .RATIO(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .en(en[1]), .fifo_rd_valid(rd_valid[1]),
      .fifo_rd_data(rd_data1), .fifo_rd_ready(rdy1), .fifo_empty(empty[1]),
      .fifo_underflow(uf1), .out_valid(out_valid[1]), .out_data(out_data1),
      .out_ready(out_ready[1]), .busy(busy[1]), .err_underflow(err_uf[1]),
      .err_unexpected(err_ux[1]));

   // FIFO model: empty flag registered from the pre-edge count (one cycle lag).
   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         empty[g]   <= (wp[g] == rp[g]);
         m_uf[g]    <= rd_valid[g] && (wp[g] == rp[g]);
         m_ready[g] <= rd_valid[g] && (wp[g] != rp[g]);
         if (rd_valid[g] && (wp[g] != rp[g])) begin
            m_data[g] <= mem[g][rp[g]];
            rp[g]     <= rp[g] + 4'd1;
         end
      end
   end

   task automatic load(input int g, input logic [3:0] w);
      mem[g][wp[g]] = w;
      wp[g] = wp[g] + 4'd1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   typedef struct {
      logic       en;
      logic       rdy;
      logic       rv;
      logic       ov;
      logic [3:0] d;
      logic       bz;
   } vec_t;

   vec_t tv [10];
   int   reqs, got, seen;
   logic stale;
   logic [7:0] beats [2];

   initial begin
      // RATIO=1 drain of 0x1,0x2,0x3, cycle by cycle after reset release
      tv[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
      tv[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0};
      tv[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1};
      tv[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 1'b1};
      tv[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1};
      tv[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h2, 1'b1};
      tv[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1};
      tv[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h3, 1'b1};
      tv[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
      tv[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};

      rst_n = 1'b0; en = '0; out_ready = '0; inj_ready = '0; inj_uf = '0; inj_data = '0;
      @(negedge clk);
      load(0, 4'h1); load(0, 4'h2); load(0, 4'h3);
      en[0] = 1'b1;
      repeat (3) cyc();
      chk("rst_rd_valid", 32'(rd_valid[0]), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err_uf", 32'(err_uf), 32'd0);
      chk("rst_err_ux", 32'(err_ux), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         en[0] = tv[i].en;
         out_ready[0] = tv[i].rdy;
         cyc();
         chk($sformatf("vec%0d_rd_valid", i), 32'(rd_valid[0]), 32'(tv[i].rv));
         chk($sformatf("vec%0d_out_valid", i), 32'(out_valid[0]), 32'(tv[i].ov));
         chk($sformatf("vec%0d_busy", i), 32'(busy[0]), 32'(tv[i].bz));
         if (tv[i].ov) chk($sformatf("vec%0d_out_data", i), 32'(out_data0), 32'(tv[i].d));
      end
      chk("drain_err_uf", 32'(err_uf[0]), 32'd0);
      chk("drain_err_ux", 32'(err_ux[0]), 32'd0);

      // Backpressure: 5 words, out_ready=0 -> only 2 requests fill the queue
      out_ready[0] = 1'b0;
      for (int w = 4; w <= 8; w++) load(0, 4'(w));
      reqs = 0;
      repeat (16) begin
         cyc();
         if (rd_valid[0]) reqs++;
      end
      chk("bp_requests", 32'(reqs), 32'd2);
      chk("bp_out_valid", 32'(out_valid[0]), 32'd1);
      chk("bp_out_data_held", 32'(out_data0), 32'h4);
      chk("bp_rd_valid_held", 32'(rd_valid[0]), 32'd0);
      chk("bp_busy", 32'(busy[0]), 32'd1);
      out_ready[0] = 1'b1;
      got = 0;
      for (int c = 0; c < 60 && got < 5; c++) begin
         if (out_valid[0]) begin
            chk($sformatf("bp_data%0d", got), 32'(out_data0), 32'(4 + got));
            got++;
         end
         cyc();
      end
      chk("bp_count", 32'(got), 32'd5);

      // Single word: lagging empty flag must not cause a second request
      repeat (3) cyc();
      load(0, 4'h9);
      reqs = 0; seen = 0;
      repeat (10) begin
         cyc();
         if (rd_valid[0]) reqs++;
         if (out_valid[0]) begin
            seen++;
            chk("single_data", 32'(out_data0), 32'h9);
         end
      end
      chk("single_requests", 32'(reqs), 32'd1);
      chk("single_seen", 32'(seen), 32'd1);
      chk("single_err_uf", 32'(err_uf[0]), 32'd0);
      en[0] = 1'b0;

      // RATIO=2 packing: 0xA,0xB,0xC,0xD -> 0xBA, 0xDC
      out_ready[1] = 1'b1;
      load(1, 4'hA); load(1, 4'hB); load(1, 4'hC); load(1, 4'hD);
      en[1] = 1'b1;
      got = 0;
      beats[0] = '0; beats[1] = '0;
      for (int c = 0; c < 40 && got < 2; c++) begin
         cyc();
         if (out_valid[1]) begin
            beats[got] = out_data1;
            got++;
         end
      end
      cyc();
      chk("pack_count", 32'(got), 32'd2);
      chk("pack_beat0", 32'(beats[0]), 32'hBA);
      chk("pack_beat1", 32'(beats[1]), 32'hDC);
      chk("pack_busy_after", 32'(busy[1]), 32'd0);
      chk("pack_out_valid_after", 32'(out_valid[1]), 32'd0);
      chk("pack_err_uf", 32'(err_uf[1]), 32'd0);

      // Reset mid-transfer with occ=1 and pack_cnt=1 (words 1,2,3, no pops)
      out_ready[1] = 1'b0;
      load(1, 4'h1); load(1, 4'h2); load(1, 4'h3);
      repeat (16) cyc();
      chk("mid_out_valid", 32'(out_valid[1]), 32'd1);
      chk("mid_out_data", 32'(out_data1), 32'h21);
      chk("mid_busy", 32'(busy[1]), 32'd1);
      inj_uf[1] = 1'b1;
      cyc();
      inj_uf[1] = 1'b0;
      chk("mid_err_uf_set", 32'(err_uf[1]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_out_valid", 32'(out_valid[1]), 32'd0);
      chk("async_busy", 32'(busy[1]), 32'd0);
      chk("async_err_uf", 32'(err_uf[1]), 32'd0);
      chk("async_out_data", 32'(out_data1), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready[1] = 1'b1;
      stale = 1'b0;
      repeat (8) begin
         cyc();
         if (out_valid[1] || busy[1]) stale = 1'b1;
      end
      chk("no_stale_beat", 32'(stale), 32'd0);
      en[1] = 1'b0;

      // Unexpected return (captured anyway) then underflow pulse; both sticky
      out_ready[0] = 1'b0;
      inj_data = 4'hE;
      inj_ready[0] = 1'b1;
      cyc();
      inj_ready[0] = 1'b0;
      chk("unexp_flag", 32'(err_ux[0]), 32'd1);
      chk("unexp_out_valid", 32'(out_valid[0]), 32'd1);
      chk("unexp_out_data", 32'(out_data0), 32'hE);
      chk("unexp_err_uf_clear", 32'(err_uf[0]), 32'd0);
      inj_uf[0] = 1'b1;
      cyc();
      inj_uf[0] = 1'b0;
      repeat (4) cyc();
      chk("sticky_err_ux", 32'(err_ux[0]), 32'd1);
      chk("sticky_err_uf", 32'(err_uf[0]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_clears_err_ux", 32'(err_ux[0]), 32'd0);
      chk("rst_clears_err_uf", 32'(err_uf[0]), 32'd0);
      chk("rst_clears_out_valid", 32'(out_valid[0]), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_reader.md
Name: fifo_reader

Overview:
- Read-side master for the team's generic FIFO; drains the FIFO read port into a valid/ready stream, with optional packing of RATIO consecutive words into one wide beat.
- Handles the FIFO's 1-cycle read latency and its registered, lagging empty flag, so it never underflows the FIFO.
- Holds returned data in a 2-entry output queue so downstream backpressure never drops a word.
- Single clock domain: sits on the FIFO's rd_clk side.

Parameters:
- WIDTH, 4, FIFO word width in bits.
- RATIO, 1, FIFO words packed per output beat (>=1; 1 = passthrough).

Ports:
- clk  input  1  clock (FIFO read clock)
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  enable issuing new FIFO reads
- fifo_rd_valid  output  1  read request to FIFO
- fifo_rd_data  input  WIDTH  FIFO read data, valid when fifo_rd_ready=1
- fifo_rd_ready  input  1  FIFO read return strobe, 1 cycle after request
- fifo_empty  input  1  FIFO registered empty flag
- fifo_underflow  input  1  FIFO underflow flag
- out_valid  output  1  output beat valid
- out_data  output  WIDTH*RATIO  packed beat; first-read word in bits [WIDTH-1:0]
- out_ready  input  1  downstream accept
- busy  output  1  request in flight, partial pack, or queue non-empty
- err_underflow  output  1  sticky: fifo_underflow seen
- err_unexpected  output  1  sticky: fifo_rd_ready with no request the previous cycle

Behaviour:
- Reset (rst_n=0, async): all outputs 0; req_q, pack_cnt, queue occupancy (occ) and sticky errors cleared; pack register and queue contents discarded. Reset mid-transfer drops all held data. Deassertion is synchronous-safe: first request no earlier than the 2nd clk edge after rst_n rises.
- Request rule (combinational):
  - fifo_rd_valid = en & !fifo_empty & !req_q & (occ<2 | pack_cnt<RATIO-1).
  - req_q is fifo_rd_valid registered. Consequence: at most one request every 2 cycles, masking the empty-flag lag.
- Return: on fifo_rd_ready=1, fifo_rd_data is written into pack slot pack_cnt.
  - If pack_cnt==RATIO-1: the full beat is pushed to the queue and pack_cnt wraps to 0.
  - Otherwise pack_cnt increments.
- Queue: 2-entry FIFO, registered outputs.
  - out_valid=1 while occ>0; out_data = head entry.
  - Pop when out_valid & out_ready. Push and pop in the same cycle leaves occ unchanged.
  - out_data is stable while out_valid=1 and out_ready=0.
  - Latency, RATIO=1, empty queue: request at cycle t, return at t+1, out_valid at t+2.
- Overflow impossible by the request rule. A push with occ==2 is a design error (assertion).
- err_unexpected: fifo_rd_ready=1 while req_q=0. The returned data is still captured.
- err_underflow: set on fifo_underflow=1. Both error flags stay set until reset.
- en=0: no new requests; an in-flight return still completes; partial pack and queue are retained and drain normally.
- busy = req_q | (pack_cnt!=0) | (occ!=0).

Test Plan:
- RATIO=1, FIFO preloaded with 0x1,0x2,0x3, out_ready=1 -> requests on alternate cycles; out_data 0x1,0x2,0x3 in order, each 2 cycles after its request; no further request once fifo_empty=1; err flags 0.
- RATIO=2, words 0xA,0xB,0xC,0xD -> two beats, out_data=0xBA then 0xDC; busy=0 after the last pop.
- RATIO=1, out_ready=0, 5 words available -> exactly 2 requests issued, occ=2, fifo_rd_valid held 0; out_data held at first word; release out_ready -> all 5 words delivered in order.
- Single word available, fifo_empty still 0 the cycle after the request -> no second request (req_q guard); err_underflow stays 0.
- Reset asserted with occ=1 and pack_cnt=1 (RATIO=2) -> out_valid, busy and errors go 0 immediately without a clock edge; no stale beat after release.
- Drive fifo_rd_ready=1 with no prior request, then pulse fifo_underflow -> err_unexpected=1 and err_underflow=1, both held until rst_n=0.
